ela_frame_streamer: RTL and testbench
=====================================

# ela_frame_streamer

Downstream stage of the ELA deinterlacer. Once the interpolator raises `done`, this block reads the completed 32×32 progressive frame from the result memory in raster order. It streams the pixels out over a valid/ready interface with row and frame markers, and it accumulates a 16-bit frame checksum for the host or testbench. It owns the result memory's read port only; the write port stays with the interpolator.

## Interface
Parameters:
- `IMG_W`, default 32: pixels per row.
- `IMG_H`, default 32: rows per frame.
- `ADDR_W`, default 10: memory address width; must equal log2(IMG_W*IMG_H).
- `FIFO_DEPTH`, default 4: output buffer entries; power of two, at least 2.

Ports:
- `clk` in, 1: clock. All logic is on the rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `start` in, 1: connected to the interpolator's `done` (a level signal). A frame launches on its rising edge.
- `mem_rd_en` in/out: out, 1: read strobe to the result memory.
- `mem_addr` out, `ADDR_W`: read address, {row[4:0], col[4:0]}.
- `mem_rdata` in, 8: read data, valid exactly 1 cycle after `mem_rd_en`.
- `out_valid` out, 1: pixel available.
- `out_ready` in, 1: the sink accepts the pixel.
- `out_data` out, 8: pixel value.
- `out_eol` out, 1: the current pixel is at col == `IMG_W`-1.
- `out_last` out, 1: the current pixel is the final pixel of the frame.
- `busy` out, 1: a frame is in progress.
- `frame_done` out, 1: single-cycle pulse at the end of a frame.
- `checksum` out, 16: sum of all pixels transferred in the frame, mod 2^16.

## Operation
- **Start detection.** A registered copy `start_q` gives the launch condition `start & ~start_q`.
  - While `busy`=1, start edges are ignored.
  - A level held high from reset launches exactly one frame, because `start_q` resets to 0.
- **FSM states:** IDLE, FETCH, DRAIN, DONE.
  - IDLE → FETCH on the launch condition. The read address, the output pixel counter and `checksum` all clear to 0.
  - FETCH: issue one read per cycle, in raster order, whenever credit allows (see credit rule). FETCH → DRAIN in the cycle after the read of address `IMG_W*IMG_H`-1 is issued.
  - DRAIN: no more reads are issued. DRAIN → DONE on the transfer of the pixel that carries `out_last`.
  - DONE: `frame_done`=1 for this one cycle, then → IDLE.
- **Credit rule.** A read is issued when `occupancy + inflight - pop < FIFO_DEPTH`.
  - `inflight` is 1 if a read was issued in the previous cycle, otherwise 0.
  - `pop` is `out_valid & out_ready`.
  - The FIFO must never overflow, and the rule must sustain one pixel per cycle when `out_ready` is held at 1.
- **FIFO push.** The FIFO is written on the cycle after each `mem_rd_en`, with `mem_rdata`.
- **Output.** The FIFO head drives `out_data`, and `out_valid` = FIFO not empty.
  - `out_eol` and `out_last` are decoded from a separate output pixel counter (0..1023) that advances on each transfer. They are not carried in the FIFO.
- **Handshake.**
  - A transfer occurs on a cycle where `out_valid` and `out_ready` are both 1.
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_eol` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
  - `out_ready` may toggle freely and has no combinational path to `out_valid`.
- **Checksum.** `checksum` += `out_data` on each transfer, with 16-bit wraparound. It holds its final value from DONE until the next launch.
- **Reset mid-frame.** The FSM returns to IDLE and the FIFO empties. Memory data returning on the next cycle is discarded. A new frame needs a fresh rising edge of `start`.

## Timing
- **Reset values:** `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_eol`=0, `out_last`=0, `busy`=0, `frame_done`=0, `checksum`=0.
- **Launch sequence.** If the launch is sampled at edge k:
  - `busy` and `mem_rd_en` are high, with `mem_addr`=0, after edge k.
  - The first FIFO push happens at edge k+2.
  - `out_valid` is high after edge k+2.
- **Full-rate frame.** With `out_ready`=1 throughout, there are 1024 transfers on consecutive cycles.
  - `frame_done` is high in the cycle after the last transfer.
  - `busy` falls together with `frame_done`.
- **Registered outputs.** `mem_addr` and `mem_rd_en` come directly from flops.

## Structure
- **Shared package `ela_pkg`:** `IMG_W`, `IMG_H`, `ADDR_W`, the pixel type (8-bit), and the streamer state enum. The interpolator reuses the image constants.
- **Sub-module `ela_out_fifo`:** a synchronous FIFO with parameter `DEPTH`.
  - Ports: push, push_data, pop, head_data, empty, full, count.
  - It has first-word fall-through: the head is visible when not empty.
- **Top level:** the FSM, start-edge detector, read and output counters, credit logic and checksum live in `ela_frame_streamer`.

## Test plan
- **Full-rate frame.** Memory preloaded with `mem[a]`=a[7:0]; `out_ready`=1; pulse `start`. Expected:
  - 1024 transfers in raster order with `out_data`=addr[7:0].
  - `out_eol` on every 32nd transfer; `out_last` only on transfer 1024.
  - `checksum`=16'hFE00 at `frame_done`.
- **Backpressure.** Same memory; `out_ready` random at 30% duty. Expected:
  - Identical data sequence and `checksum`=16'hFE00.
  - `out_data` stable whenever valid & !ready.
  - No FIFO overflow: `occupancy + inflight` ≤ 4 at all times.
- **Stalled sink.** Hold `out_ready`=0 for 50 cycles after launch. Expected:
  - Exactly 4 reads issued (addresses 0..3), then `mem_rd_en` stays 0.
  - After release, the stream resumes at pixel 0 with no loss.
- **Start level and re-trigger.** Hold `start`=1 through and after a frame; pulse `start` again mid-frame. Expected:
  - Exactly one frame runs and mid-frame edges are ignored.
  - A second frame launches only after `start` goes 0 then 1.
- **Reset mid-frame.** Assert `rst` at transfer 500. Expected:
  - All outputs at their reset values on the next cycle.
  - A subsequent launch streams a full 1024-pixel frame from address 0 with the correct checksum.
- **Constant image.** All pixels 8'hFF. Expected: `checksum` = 1024*255 mod 65536 = 16'hFC00.

Source files
------------

// File: rtl/ela_pkg.sv
// Shared ELA deinterlacer constants and types; the interpolator reuses the image geometry.
package ela_pkg;
    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 10;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } strm_state_t;

    // Running frame checksum: 16-bit wraparound sum of pixels.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input pixel_t px);
        return acc + {8'h00, px};
    endfunction
endpackage

// File: rtl/ela_frame_streamer_if.sv
// Result-memory read port plus pixel stream; master = streamer, slave = memory/sink side.
interface ela_frame_streamer_if #(parameter int ADDR_W = ela_pkg::ADDR_W);
    import ela_pkg::*;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    pixel_t            mem_rdata;
    logic              out_valid;
    logic              out_ready;
    pixel_t            out_data;
    logic              out_eol;
    logic              out_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output out_valid, out_data, out_eol, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  out_valid, out_data, out_eol, out_last,
        output out_ready
    );
endinterface

// File: rtl/ela_out_fifo.sv
// Synchronous first-word-fall-through pixel FIFO; the head is visible whenever not empty.
module ela_out_fifo
    import ela_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  pixel_t           push_data,
    input  logic             pop,
    output pixel_t           head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    pixel_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (cnt_q == CNT_W'(0));
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign count     = cnt_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/ela_frame_streamer.sv
// Reads a finished frame from the result memory in raster order and streams it out
// over valid/ready with row/frame markers and a running 16-bit checksum.
module ela_frame_streamer #(
    parameter int IMG_W      = ela_pkg::IMG_W,
    parameter int IMG_H      = ela_pkg::IMG_H,
    parameter int ADDR_W     = ela_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    ela_frame_streamer_if.master bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          checksum
);
    import ela_pkg::*;

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int COL_W = $clog2(IMG_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

    strm_state_t       state_q;
    logic              start_q;
    logic              rd_en_q;
    logic              rd_pend_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] pix_cnt_q;
    logic [ADDR_W-1:0] pix_cnt_d;
    logic [COL_W-1:0]  col_q;
    logic [COL_W-1:0]  col_d;
    logic [15:0]       csum_q;
    logic [15:0]       csum_d;

    pixel_t            head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              valid_s;
    logic              pop_s;
    logic              launch_s;
    logic              eol_s;
    logic              last_s;
    logic [CRD_W-1:0]  commit_s;
    logic [CRD_W-1:0]  limit_s;
    logic              credit_ok_s;

    // Data returning one cycle after each read is pushed; rd_pend_q clears on reset,
    // so a read in flight across a reset is dropped.
    ela_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .push_data (bus.mem_rdata),
        .pop       (pop_s),
        .head_data (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    assign valid_s  = ~fifo_empty_s;
    assign pop_s    = valid_s & bus.out_ready;
    assign launch_s = start & ~start_q & (state_q == ST_IDLE);
    assign eol_s    = valid_s & (col_q == LAST_COL);
    assign last_s   = valid_s & (pix_cnt_q == LAST_ADDR);

    // Credit counts the read being issued now and the one whose data returns now,
    // since mem_rd_en is itself registered one cycle ahead of the read it decides.
    assign commit_s    = CRD_W'(fifo_count_s) + CRD_W'(rd_en_q) + CRD_W'(rd_pend_q);
    assign limit_s     = CRD_W'(FIFO_DEPTH) + CRD_W'(pop_s);
    assign credit_ok_s = (commit_s < limit_s) & (pop_s | ~fifo_full_s);

    // Next-state values for the output-side counters.
    always_comb begin
        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        csum_d    = csum_add(csum_q, head_s);
        if (col_q == LAST_COL) begin
            col_d = '0;
        end else begin
            col_d = col_q + COL_W'(1);
        end
    end

    // Control FSM with registered read strobe, address, busy and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            start_q   <= start;
            rd_pend_q <= rd_en_q;
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (launch_s) begin
                        state_q   <= ST_FETCH;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end else begin
                        rd_en_q   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (rd_en_q && (rd_addr_q == LAST_ADDR)) begin
                        state_q <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_en_q <= credit_ok_s;
                        if (rd_en_q) rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    rd_en_q <= 1'b0;
                    if (pop_s && last_s) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output pixel position and checksum; both restart on launch and hold after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q <= '0;
            col_q     <= '0;
            csum_q    <= 16'h0000;
        end else if (launch_s) begin
            pix_cnt_q <= '0;
            col_q     <= '0;
            csum_q    <= 16'h0000;
        end else if (pop_s) begin
            pix_cnt_q <= pix_cnt_d;
            col_q     <= col_d;
            csum_q    <= csum_d;
        end
    end

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = rd_addr_q;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = valid_s ? head_s : 8'h00;
    assign bus.out_eol   = eol_s;
    assign bus.out_last  = last_s;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign checksum      = csum_q;
endmodule

// File: tb/tb_ela_frame_streamer.sv
// Scoreboard bench for ela_frame_streamer: expected pixels are queued per launched frame
// and a free-running monitor checks every transfer and every frame_done.
module tb_ela_frame_streamer;
    import ela_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       eol;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [15:0] checksum;

    ela_frame_streamer_if #(.ADDR_W(10)) bus ();

    ela_frame_streamer #(
        .IMG_W(32), .IMG_H(32), .ADDR_W(10), .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:1023];
    exp_t        exp_q [$];
    logic [15:0] cks_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          outstanding = 0;
    int          max_out = 0;
    int          ready_mode = 0;
    logic        hold_v = 1'b0;
    logic [10:0] hold_val = 11'd0;
    exp_t        mon_e;
    logic [15:0] mon_cks;

    // Synchronous-read result memory model.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sink: ready pattern selected by ready_mode (0 always, 1 ~30%, 2 never).
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 9) < 3);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples between edges what the next rising edge will act on.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    check("hold_stable", 64'({bus.out_valid, bus.out_data, bus.out_eol, bus.out_last}),
                          64'(hold_val));
                if (bus.mem_rd_en) outstanding++;
                if (outstanding > max_out) max_out = outstanding;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", 64'(bus.out_data), 64'hDEAD);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check($sformatf("pix%0d", xfer_cnt),
                              64'({bus.out_data, bus.out_eol, bus.out_last}), 64'(mon_e));
                    end
                    if (xfer_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    xfer_cnt++;
                    outstanding--;
                end
                hold_v   = bus.out_valid && !bus.out_ready;
                hold_val = {1'b1, bus.out_data, bus.out_eol, bus.out_last};
                if (frame_done) begin
                    if (cks_q.size() == 0) begin
                        check("unexpected_frame_done", 64'(checksum), 64'hDEAD);
                    end else begin
                        mon_cks = cks_q.pop_front();
                        check("checksum", 64'(checksum), 64'(mon_cks));
                    end
                    check("done_after_last", 64'(cyc - last_cyc), 64'd1);
                    check("all_pixels_seen", 64'(exp_q.size()), 64'd0);
                    check("busy_low_at_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic load_mem(input bit konst);
        for (int i = 0; i < 1024; i++) mem[i] = konst ? 8'hFF : 8'(i);
    endtask

    task automatic expect_frame(input bit konst, input logic [15:0] cks);
        exp_t e;
        for (int i = 0; i < 1024; i++) begin
            e.data = konst ? 8'hFF : 8'(i);
            e.eol  = ((i % 32) == 31);
            e.last = (i == 1023);
            exp_q.push_back(e);
        end
        cks_q.push_back(cks);
        xfer_cnt = 0;
        max_out  = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", 64'(frame_done), 64'd1);
        @(negedge clk);
        check("no_overflow", 64'(max_out <= 4), 64'd1);
    endtask

    initial begin
        logic [9:0] ra [$];
        int n;
        rst   = 1'b1;
        start = 1'b0;
        load_mem(1'b0);
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_data,
              bus.out_eol, bus.out_last, busy, frame_done, checksum}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-rate frame with launch timing.
        ready_mode = 0;
        expect_frame(1'b0, 16'hFE00);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("launch_state", 64'({busy, bus.mem_rd_en, bus.mem_addr, bus.out_valid}),
              64'({1'b1, 1'b1, 10'd0, 1'b0}));
        @(posedge clk);
        #1;
        check("valid_at_k1", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("valid_at_k2", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        check("full_rate_span", 64'(last_cyc - first_cyc), 64'd1023);
        check("full_rate_count", 64'(xfer_cnt), 64'd1024);

        // Random backpressure.
        ready_mode = 1;
        expect_frame(1'b0, 16'hFE00);
        pulse_start();
        wait_done(9000);

        // Stalled sink: four reads then nothing until released.
        ready_mode = 2;
        expect_frame(1'b0, 16'hFE00);
        @(negedge clk);
        start = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.mem_rd_en) ra.push_back(bus.mem_addr);
        end
        start = 1'b0;
        check("stall_read_count", 64'(ra.size()), 64'd4);
        for (int i = 0; i < 4 && i < ra.size(); i++)
            check($sformatf("stall_addr%0d", i), 64'(ra[i]), 64'(i));
        check("stall_rd_en_low", 64'(bus.mem_rd_en), 64'd0);
        check("stall_no_xfer", 64'(xfer_cnt), 64'd0);
        ready_mode = 0;
        wait_done(3000);

        // Start held high, re-pulsed mid-frame: only one frame.
        expect_frame(1'b0, 16'hFE00);
        @(negedge clk);
        start = 1'b1;
        repeat (300) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_done(3000);
        repeat (40) @(negedge clk);
        check("no_relaunch_busy", 64'(busy), 64'd0);
        check("no_relaunch_pixels", 64'(xfer_cnt), 64'd1024);
        start = 1'b0;
        @(negedge clk);
        expect_frame(1'b0, 16'hFE00);
        start = 1'b1;
        wait_done(3000);
        start = 1'b0;

        // Reset at transfer 500, then a clean frame.
        expect_frame(1'b0, 16'hFE00);
        pulse_start();
        n = 0;
        while (xfer_cnt < 500 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_xfer_500", 64'(xfer_cnt >= 500), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        cks_q.delete();
        outstanding = 0;
        @(posedge clk);
        #1;
        check("midframe_reset_outputs", 64'({bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_data,
              bus.out_eol, bus.out_last, busy, frame_done, checksum}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", 64'({busy, bus.out_valid}), 64'd0);
        expect_frame(1'b0, 16'hFE00);
        pulse_start();
        wait_done(3000);

        // Constant 8'hFF image.
        load_mem(1'b1);
        expect_frame(1'b1, 16'hFC00);
        pulse_start();
        wait_done(3000);

        check("scoreboard_empty", 64'(exp_q.size() + cks_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
